// File: rtl/ant_switch_allocator_if.sv
// Router switch-allocation bundle: per-input packets/requests in, per-output packets and credits.
// master = upstream/downstream environment, slave = the allocator.
interface ant_switch_allocator_if #(
    parameter int N_IN   = 5,
    parameter int N_OUT  = 5,
    parameter int DATA_W = 64
);
    logic [N_IN-1:0][DATA_W-1:0]  i_data;
    logic [N_IN-1:0]              i_data_val;
    logic [N_IN-1:0][N_OUT-1:0]   i_output_req;
    logic [N_OUT-1:0]             i_credit;
    logic [N_IN-1:0]              o_grant;
    logic [N_OUT-1:0][DATA_W-1:0] o_data;
    logic [N_OUT-1:0]             o_data_val;
    logic                         o_req_err;
    logic                         o_credit_err;

    modport master (
        output i_data, i_data_val, i_output_req, i_credit,
        input  o_grant, o_data, o_data_val, o_req_err, o_credit_err
    );

    modport slave (
        input  i_data, i_data_val, i_output_req, i_credit,
        output o_grant, o_data, o_data_val, o_req_err, o_credit_err
    );
endinterface

// File: rtl/ant_switch_allocator.sv
// Per-output round-robin switch allocator with credit-based flow control toward each output.
// Latency: o_grant combinational, o_data/o_data_val registered 1 cycle after grant.
// Backpressure: an output with zero credits grants nobody; ungranted inputs hold until o_grant.
module ant_switch_allocator #(
    parameter int N_IN    = 5,
    parameter int N_OUT   = 5,
    parameter int CREDITS = 4,
    parameter int DATA_W  = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    ant_switch_allocator_if.slave  bus
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic [CW-1:0]                cred   [N_OUT];
    logic [PW-1:0]                rr_ptr [N_OUT];
    logic [PW-1:0]                win    [N_OUT];
    logic [N_OUT-1:0]             out_gnt;
    logic [N_OUT-1:0][N_IN-1:0]   elig;
    logic [N_IN-1:0]              req_ok;
    logic [N_IN-1:0]              grant;
    logic                         req_bad;

    // Only a valid, exactly one-hot request is ever a candidate; anything else is flagged.
    always_comb begin
        req_ok  = '0;
        req_bad = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            req_ok[i] = bus.i_data_val[i] && $onehot(bus.i_output_req[i]);
            if (bus.i_data_val[i] && !$onehot(bus.i_output_req[i]))
                req_bad = 1'b1;
        end
    end

    always_comb begin
        elig = '0;
        for (int j = 0; j < N_OUT; j++)
            for (int i = 0; i < N_IN; i++)
                elig[j][i] = req_ok[i] && bus.i_output_req[i][j] && (cred[j] != '0);
    end

    always_comb begin
        int idx;
        idx     = 0;
        out_gnt = '0;
        for (int j = 0; j < N_OUT; j++) begin
            win[j] = '0;
            for (int k = 0; k < N_IN; k++) begin
                idx = (int'(rr_ptr[j]) + k) % N_IN;
                if (!out_gnt[j] && elig[j][idx]) begin
                    out_gnt[j] = 1'b1;
                    win[j]     = PW'(idx);
                end
            end
        end
        // Packets granted while in reset would be lost, so no upstream pop either.
        if (!reset_n)
            out_gnt = '0;
    end

    always_comb begin
        grant = '0;
        for (int j = 0; j < N_OUT; j++)
            for (int i = 0; i < N_IN; i++)
                if (out_gnt[j] && (win[j] == PW'(i)))
                    grant[i] = 1'b1;
    end

    assign bus.o_grant = grant;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.o_data       <= '0;
            bus.o_data_val   <= '0;
            bus.o_req_err    <= 1'b0;
            bus.o_credit_err <= 1'b0;
            for (int j = 0; j < N_OUT; j++) begin
                cred[j]   <= CW'(CREDITS);
                rr_ptr[j] <= '0;
            end
        end else begin
            if (req_bad)
                bus.o_req_err <= 1'b1;
            for (int j = 0; j < N_OUT; j++) begin
                bus.o_data_val[j] <= out_gnt[j];
                if (out_gnt[j]) begin
                    bus.o_data[j] <= bus.i_data[win[j]];
                    rr_ptr[j]     <= (win[j] == PW'(N_IN - 1)) ? '0 : win[j] + PW'(1);
                end
                // Simultaneous grant and returned credit cancel out.
                case ({out_gnt[j], bus.i_credit[j]})
                    2'b10: cred[j] <= cred[j] - CW'(1);
                    2'b01: begin
                        if (cred[j] == CW'(CREDITS))
                            bus.o_credit_err <= 1'b1;
                        else
                            cred[j] <= cred[j] + CW'(1);
                    end
                    default: cred[j] <= cred[j];
                endcase
            end
        end
    end
endmodule
